// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, burst-master state type and burst-shape helpers
// used by the burst master and its address generator.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_BEAT,
        ST_LAST,
        ST_ERR,
        ST_DONE
    } state_e;

    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4, HBURST_INCR4:   return 5'd4;
            HBURST_WRAP8, HBURST_INCR8:   return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                      return 5'd1;
        endcase
    endfunction

    // Byte-address bits that wrap for WRAPn bursts; zero means plain increment.
    function automatic logic [9:0] wrap_mask(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4:  return 10'h00f;
            HBURST_WRAP8:  return 10'h01f;
            HBURST_WRAP16: return 10'h03f;
            default:       return 10'h000;
        endcase
    endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Combinational beat-address stepper (incrementing or wrapping) and the
// 1KB-boundary check applied to an incoming INCRn command.
module ahb_addr_gen #(
    parameter int AWIDTH = 20
) (
    input  logic [AWIDTH-1:0] addr,
    input  logic [2:0]        burst,
    output logic [AWIDTH-1:0] next_addr,
    input  logic [AWIDTH-1:0] chk_addr,
    input  logic [2:0]        chk_burst,
    output logic              crosses_1k
);
    import ahb_pkg::*;

    logic [AWIDTH-1:0] incr;
    logic [AWIDTH-1:0] mask;
    logic [AWIDTH-1:0] last_addr;
    logic              is_incrn;

    always_comb begin
        incr      = addr + AWIDTH'(4);
        mask      = AWIDTH'(wrap_mask(burst));
        next_addr = (mask == '0) ? incr : ((addr & ~mask) | (incr & mask));

        last_addr  = chk_addr + AWIDTH'({burst_beats(chk_burst) - 5'd1, 2'b00});
        is_incrn   = (chk_burst == HBURST_INCR4) || (chk_burst == HBURST_INCR8) ||
                     (chk_burst == HBURST_INCR16);
        crosses_1k = is_incrn && (chk_addr[AWIDTH-1:10] != last_addr[AWIDTH-1:10]);
    end

endmodule

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: converts one command into a fixed-length burst,
// pulling write beats from a show-ahead source and streaming read beats out.
module ahb_burst_master #(
    parameter int AWIDTH = 20,
    parameter int DWIDTH = 32
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [2:0]        cmd_burst,
    input  logic              src_empty,
    input  logic [DWIDTH-1:0] src_data,
    output logic              src_pop,
    output logic              rd_valid,
    output logic [DWIDTH-1:0] rd_data,
    output logic              done,
    output logic              err,
    output logic              hsel,
    output logic [AWIDTH-1:0] haddr,
    output logic [2:0]        hburst,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [DWIDTH-1:0] hwdata,
    input  logic [DWIDTH-1:0] hrdata,
    input  logic              hready,
    input  logic [1:0]        hresp
);
    import ahb_pkg::*;

    state_e            state, state_nxt;
    logic [AWIDTH-1:0] addr_q;
    logic [2:0]        burst_q;
    logic              write_q;
    logic [4:0]        beats_left;
    logic              dphase_q;
    logic              stall_q;
    logic [1:0]        htrans_q;
    logic              err_q;
    logic              rd_valid_q;
    logic [DWIDTH-1:0] rdata_q;
    logic [DWIDTH-1:0] wdata_q;

    logic [AWIDTH-1:0] next_addr;
    logic              crosses_1k;
    logic              accept, reject, resp_err, beat_go, last_beat;

    ahb_addr_gen #(.AWIDTH(AWIDTH)) u_addr_gen (
        .addr       (addr_q),
        .burst      (burst_q),
        .next_addr  (next_addr),
        .chk_addr   (cmd_addr),
        .chk_burst  (cmd_burst),
        .crosses_1k (crosses_1k)
    );

    // NOTE: every signal written in an always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        cmd_ready = (state == ST_IDLE) && hreset;
        hsel      = (state == ST_ADDR) || (state == ST_BEAT) || (state == ST_LAST) || (state == ST_ERR);
        resp_err  = dphase_q && (hresp != HRESP_OKAY);
        htrans    = HTRANS_IDLE;
        if (resp_err)
            htrans = HTRANS_IDLE;
        else if (stall_q)
            htrans = htrans_q;   // transfer type frozen while the slave inserts wait states
        else if (state == ST_ADDR)
            htrans = (write_q && src_empty) ? HTRANS_IDLE : HTRANS_NONSEQ;
        else if (state == ST_BEAT)
            htrans = (write_q && src_empty) ? HTRANS_BUSY : HTRANS_SEQ;
        beat_go   = hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
        last_beat = (beats_left == 5'd1);
        src_pop   = write_q && beat_go;
        accept    = cmd_valid && cmd_ready;
        reject    = (cmd_burst == HBURST_INCR) || (cmd_addr[1:0] != 2'b00) || crosses_1k;
        done      = (state == ST_DONE);
        err       = done && err_q;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = reject ? ST_DONE : ST_ADDR;
            ST_ADDR: if (beat_go) state_nxt = last_beat ? ST_LAST : ST_BEAT;
            ST_BEAT: begin
                if (resp_err)
                    state_nxt = hready ? ST_DONE : ST_ERR;
                else if (beat_go && last_beat)
                    state_nxt = ST_LAST;
            end
            ST_LAST: begin
                if (resp_err)
                    state_nxt = hready ? ST_DONE : ST_ERR;
                else if (hready)
                    state_nxt = ST_DONE;
            end
            ST_ERR:  if (hready) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge hclk) begin
        if (!hreset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge hclk) begin
        if (!hreset) begin
            addr_q     <= '0;
            burst_q    <= '0;
            write_q    <= 1'b0;
            beats_left <= '0;
            dphase_q   <= 1'b0;
            stall_q    <= 1'b0;
            htrans_q   <= HTRANS_IDLE;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rdata_q    <= '0;
            wdata_q    <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            stall_q    <= !hready && ((state == ST_ADDR) || (state == ST_BEAT));
            htrans_q   <= htrans;
            if (accept) begin
                addr_q     <= cmd_addr;
                burst_q    <= cmd_burst;
                write_q    <= cmd_write;
                beats_left <= burst_beats(cmd_burst);
                err_q      <= reject;
            end
            if (beat_go && !last_beat) begin
                addr_q     <= next_addr;
                beats_left <= beats_left - 5'd1;
            end
            if (resp_err)
                err_q <= 1'b1;
            if (hready)
                dphase_q <= beat_go;
            if (src_pop)
                wdata_q <= src_data;
            if (dphase_q && hready && (hresp == HRESP_OKAY) && !write_q) begin
                rd_valid_q <= 1'b1;
                rdata_q    <= hrdata;
            end
        end
    end

    assign haddr    = addr_q;
    assign hburst   = burst_q;
    assign hwrite   = write_q;
    assign hwdata   = wdata_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rdata_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: a show-ahead source queue feeds writes,
// hrdata/hready/hresp are driven per cycle, expectations are hand-computed.
module tb_ahb_burst_master;
    import ahb_pkg::*;

    logic        hclk, hreset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [19:0] cmd_addr;
    logic [2:0]  cmd_burst;
    logic        src_empty, src_pop;
    logic [31:0] src_data;
    logic        rd_valid, done, err;
    logic [31:0] rd_data;
    logic        hsel, hwrite, hready;
    logic [19:0] haddr;
    logic [2:0]  hburst;
    logic [1:0]  htrans, hresp;
    logic [31:0] hwdata, hrdata;

    int tests_run    = 0;
    int tests_failed = 0;
    int pops         = 0;
    int dbeat        = 0;
    int rcount       = 0;
    logic [31:0] src_q[$];
    logic [19:0] wrap_addr[8] = '{20'h1C, 20'h00, 20'h04, 20'h08, 20'h0C, 20'h10, 20'h14, 20'h18};

    ahb_burst_master dut (
        .hclk(hclk), .hreset(hreset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_burst(cmd_burst),
        .src_empty(src_empty), .src_data(src_data), .src_pop(src_pop),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
        .hsel(hsel), .haddr(haddr), .hburst(hburst), .htrans(htrans), .hwrite(hwrite),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    function automatic logic [31:0] dword(input int k);
        return 32'hD0D0_0000 + 32'(k);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic src_refresh();
        src_empty = (src_q.size() == 0);
        src_data  = src_empty ? 32'h0 : src_q[0];
    endtask

    // Samples src_pop before the edge and retires the popped word after it.
    task automatic tick();
        logic pop;
        pop = src_pop;
        @(posedge hclk);
        #1;
        if (pop && src_q.size() != 0) begin
            void'(src_q.pop_front());
            pops++;
        end
        src_refresh();
    endtask

    task automatic issue(input logic wr, input logic [19:0] a, input logic [2:0] b);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_burst = b;
        #1;
        check("cmd_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        hreset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_burst = '0;
        hready = 1'b1; hresp = HRESP_OKAY; hrdata = '0;
        src_refresh();

        // Reset state
        tick(); tick();
        #1;
        check("rst htrans", htrans, HTRANS_IDLE);
        check("rst hsel", hsel, 1'b0);
        check("rst cmd_ready", cmd_ready, 1'b0);
        check("rst done", done, 1'b0);
        check("rst haddr", haddr, 20'h0);
        check("rst hwdata", hwdata, 32'h0);
        hreset = 1'b1;
        tick();

        // 1: write INCR4 @0x100
        for (int k = 0; k < 4; k++) src_q.push_back(32'hA0A0_0000 + 32'(k));
        src_refresh();
        pops = 0;
        issue(1'b1, 20'h00100, HBURST_INCR4);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t1 htrans", htrans, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
            check("t1 haddr", haddr, 20'h100 + 20'(4 * i));
            check("t1 src_pop", src_pop, 1'b1);
            check("t1 hsel", hsel, 1'b1);
            if (i > 0) check("t1 hwdata", hwdata, 32'hA0A0_0000 + 32'(i - 1));
            tick();
        end
        #1;
        check("t1 last htrans", htrans, HTRANS_IDLE);
        check("t1 last hwdata", hwdata, 32'hA0A0_0003);
        check("t1 last done", done, 1'b0);
        tick();
        #1;
        check("t1 done", done, 1'b1);
        check("t1 err", err, 1'b0);
        check("t1 hsel off", hsel, 1'b0);
        check("t1 pops", pops, 4);
        tick();

        // 2: read WRAP8 @0x1C
        issue(1'b0, 20'h0001C, HBURST_WRAP8);
        for (int i = 0; i < 10; i++) begin
            hrdata = (i >= 1 && i <= 8) ? dword(i - 1) : 32'h0;
            #1;
            if (i < 8) begin
                check("t2 htrans", htrans, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
                check("t2 haddr", haddr, wrap_addr[i]);
                check("t2 hwrite", hwrite, 1'b0);
            end else if (i == 8) begin
                check("t2 last htrans", htrans, HTRANS_IDLE);
            end
            if (i >= 2) begin
                check("t2 rd_valid", rd_valid, 1'b1);
                check("t2 rd_data", rd_data, dword(i - 2));
            end else begin
                check("t2 rd_valid idle", rd_valid, 1'b0);
            end
            if (i == 9) begin
                check("t2 done", done, 1'b1);
                check("t2 err", err, 1'b0);
            end
            tick();
        end
        hrdata = '0;

        // 3: write INCR8 @0x200, source runs dry after beat 2 for 3 cycles
        for (int k = 0; k < 3; k++) src_q.push_back(32'hB0B0_0000 + 32'(k));
        src_refresh();
        pops = 0;
        issue(1'b1, 20'h00200, HBURST_INCR8);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3 htrans", htrans, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
            check("t3 haddr", haddr, 20'h200 + 20'(4 * i));
            check("t3 src_pop", src_pop, 1'b1);
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            #1;
            check("t3 busy htrans", htrans, HTRANS_BUSY);
            check("t3 busy haddr", haddr, 20'h20C);
            check("t3 busy src_pop", src_pop, 1'b0);
            check("t3 busy hwdata", hwdata, 32'hB0B0_0002);
            tick();
        end
        for (int k = 3; k < 8; k++) src_q.push_back(32'hB0B0_0000 + 32'(k));
        src_refresh();
        for (int i = 3; i < 8; i++) begin
            #1;
            check("t3 htrans", htrans, HTRANS_SEQ);
            check("t3 haddr", haddr, 20'h200 + 20'(4 * i));
            check("t3 hwdata", hwdata, 32'hB0B0_0000 + 32'(i - 1));
            tick();
        end
        #1;
        check("t3 last hwdata", hwdata, 32'hB0B0_0007);
        tick();
        #1;
        check("t3 done", done, 1'b1);
        check("t3 pops", pops, 8);
        tick();

        // 4: read INCR16 @0x400, two wait states while beat 5 is addressed
        dbeat = 0;
        rcount = 0;
        issue(1'b0, 20'h00400, HBURST_INCR16);
        for (int i = 1; i <= 20; i++) begin
            hready = !(i == 6 || i == 7);
            hrdata = dword(dbeat);
            #1;
            if (i >= 6 && i <= 8) begin
                check("t4 hold htrans", htrans, HTRANS_SEQ);
                check("t4 hold haddr", haddr, 20'h414);
            end
            if (i == 9) check("t4 resume haddr", haddr, 20'h418);
            if (i == 7 || i == 8) check("t4 stall rd_valid", rd_valid, 1'b0);
            if (rd_valid) begin
                check("t4 rd_data", rd_data, dword(rcount));
                rcount++;
            end
            if (i == 20) check("t4 done", done, 1'b1);
            tick();
            if (i >= 2 && hready) dbeat++;
        end
        check("t4 beat count", rcount, 16);
        hready = 1'b1;
        hrdata = '0;

        // 5: write INCR4 @0x500, ERROR response on beat 2
        for (int k = 0; k < 4; k++) src_q.push_back(32'hE0E0_0000 + 32'(k));
        src_refresh();
        pops = 0;
        issue(1'b1, 20'h00500, HBURST_INCR4);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5 htrans", htrans, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
            tick();
        end
        hready = 1'b0; hresp = HRESP_ERROR;
        #1;
        check("t5 err1 htrans", htrans, HTRANS_IDLE);
        check("t5 err1 src_pop", src_pop, 1'b0);
        tick();
        hready = 1'b1;
        #1;
        check("t5 err2 htrans", htrans, HTRANS_IDLE);
        check("t5 err2 done", done, 1'b0);
        tick();
        hresp = HRESP_OKAY;
        #1;
        check("t5 done", done, 1'b1);
        check("t5 err", err, 1'b1);
        check("t5 htrans", htrans, HTRANS_IDLE);
        check("t5 pops", pops, 3);
        tick();
        src_q.delete();
        src_refresh();

        // 6: rejected commands, then reset mid-burst
        issue(1'b0, 20'h00800, HBURST_INCR);
        #1;
        check("t6 incr done", done, 1'b1);
        check("t6 incr err", err, 1'b1);
        check("t6 incr htrans", htrans, HTRANS_IDLE);
        check("t6 incr hsel", hsel, 1'b0);
        tick();
        issue(1'b0, 20'h003F8, HBURST_INCR16);
        #1;
        check("t6 1k done", done, 1'b1);
        check("t6 1k err", err, 1'b1);
        check("t6 1k htrans", htrans, HTRANS_IDLE);
        tick();
        issue(1'b1, 20'h00102, HBURST_SINGLE);
        #1;
        check("t6 unaligned err", err, 1'b1);
        check("t6 unaligned src_pop", src_pop, 1'b0);
        tick();

        for (int k = 0; k < 4; k++) src_q.push_back(32'hF0F0_0000 + 32'(k));
        src_refresh();
        issue(1'b1, 20'h00600, HBURST_INCR4);
        #1;
        tick();
        #1;
        check("t6 mid haddr", haddr, 20'h604);
        hreset = 1'b0;
        tick();
        #1;
        check("t6 rst htrans", htrans, HTRANS_IDLE);
        check("t6 rst hsel", hsel, 1'b0);
        check("t6 rst haddr", haddr, 20'h0);
        check("t6 rst hburst", hburst, 3'b000);
        check("t6 rst hwrite", hwrite, 1'b0);
        check("t6 rst hwdata", hwdata, 32'h0);
        check("t6 rst src_pop", src_pop, 1'b0);
        check("t6 rst done", done, 1'b0);
        check("t6 rst cmd_ready", cmd_ready, 1'b0);
        hreset = 1'b1;
        tick();
        #1;
        check("t6 post cmd_ready", cmd_ready, 1'b1);
        check("t6 post done", done, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
